// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product,
// signed or unsigned per operation, valid/ready on both sides.
module seq_multiplier #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [PW-1:0]      mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [PW-1:0]      acc_reg;
  logic [CW-1:0]      count_reg;
  logic               sign_reg;
  logic [PW-1:0]      p_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;
  logic               busy_reg;

  // Operand magnitudes: conditional invert then add the sign bit. The most
  // negative value maps onto 2^(WIDTH-1), which still fits unsigned.
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   a_flip;
  logic [WIDTH-1:0]   b_flip;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign neg_a = is_signed & a[WIDTH-1];
  assign neg_b = is_signed & b[WIDTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_flip
      assign a_flip[gi] = a[gi] ^ neg_a;
      assign b_flip[gi] = b[gi] ^ neg_b;
    end
  endgenerate

  assign a_mag = a_flip + {{(WIDTH-1){1'b0}}, neg_a};
  assign b_mag = b_flip + {{(WIDTH-1){1'b0}}, neg_b};

  logic [PW-1:0] acc_next;
  logic [PW-1:0] prod_final;

  always_comb begin
    acc_next   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    prod_final = sign_reg ? (~acc_next + PW'(1)) : acc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      count_reg     <= '0;
      sign_reg      <= 1'b0;
      p_reg         <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg    <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg   <= b_mag;
            sign_reg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_reg      <= '0;
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          // The multiplicand is shifted each step, so it always equals a << count.
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + CW'(1);
          if (count_reg == LAST_COUNT) begin
            p_reg         <= prod_final;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign p         = p_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed WIDTH=3 cases and randomized
// WIDTH=8 traffic, both checked against an integer-arithmetic reference.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv3, ir3, s3, ov3, or3, busy3;
  logic [2:0] a3, b3;
  logic [5:0] p3;

  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  seq_multiplier #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .is_signed(s3), .out_valid(ov3), .out_ready(or3), .p(p3), .busy(busy3)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  typedef struct {
    logic [63:0] p;
    int          acc_cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv,
                                          input bit sg, input int w);
    longint x, y, pr;
    x = longint'(av);
    y = longint'(bv);
    if (sg) begin
      if (av[w-1]) x = x - (longint'(1) << w);
      if (bv[w-1]) y = y - (longint'(1) << w);
    end
    pr = x * y;
    return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Monitors sample just after the driver's negedge updates, i.e. with the
  // values the next rising edge will see.
  logic prev_ov3 = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (ov3 && !prev_ov3) begin
        if (q3.size() == 0) fail_now("unexpected_out3");
        else check("latency3", 64'(cyc - q3[0].acc_cyc), 64'd3);
      end
      if (ov3 && or3) begin
        if (q3.size() == 0) fail_now("pop_empty3");
        else begin
          check("p3", 64'(p3), q3[0].p);
          $display("w3 txn: p=%0h expected=%0h", p3, q3[0].p);
          void'(q3.pop_front());
        end
      end
    end
    prev_ov3 = ov3;
  end

  logic prev_ov8 = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (ov8 && !prev_ov8) begin
        if (q8.size() == 0) fail_now("unexpected_out8");
        else check("latency8", 64'(cyc - q8[0].acc_cyc), 64'd8);
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) fail_now("pop_empty8");
        else begin
          check("p8", 64'(p8), q8[0].p);
          $display("w8 txn: p=%0h expected=%0h", p8, q8[0].p);
          void'(q8.pop_front());
        end
      end
    end
    prev_ov8 = ov8;
  end

  task automatic issue3(input logic [2:0] av, input logic [2:0] bv, input bit sg, input bit push);
    int n = 0;
    @(negedge clk);
    iv3 = 1'b1; a3 = av; b3 = bv; s3 = sg;
    while (!ir3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir3) fail_now("issue3_timeout");
    else if (push) q3.push_back('{ref_mul(32'(av), 32'(bv), sg, 3), cyc + 1});
    @(negedge clk);
    iv3 = 1'b0;
    a3 = 3'($urandom);
    b3 = 3'($urandom);
    check("busy_after_accept3", {62'd0, busy3, ir3}, 64'b10);
  endtask

  task automatic wait_idle3();
    int n = 0;
    while (!(ir3 && q3.size() == 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("idle3_timeout");
  endtask

  logic [7:0] ta[4] = '{8'h80, 8'hFF, 8'h00, 8'h80};
  logic [7:0] tb[4] = '{8'h80, 8'hFF, 8'hC8, 8'h01};
  bit         ts[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int k = 0;
    int naccept = 0;
    int n;
    rst_n = 1'b0;
    iv3 = 1'b0; a3 = '0; b3 = '0; s3 = 1'b0; or3 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready3", 64'(ir3), 64'd1);
    check("rst_out_valid3", 64'(ov3), 64'd0);
    check("rst_p3", 64'(p3), 64'd0);
    check("rst_busy3", 64'(busy3), 64'd0);
    check("rst_in_ready8", 64'(ir8), 64'd1);
    check("rst_p8", 64'(p8), 64'd0);
    rst_n = 1'b1;

    issue3(3'd3, 3'd3, 1'b0, 1'b1);
    issue3(3'd7, 3'd7, 1'b0, 1'b1);
    issue3(3'd0, 3'd5, 1'b0, 1'b1);
    issue3(3'b100, 3'b011, 1'b1, 1'b1);
    issue3(3'b100, 3'b100, 1'b1, 1'b1);
    issue3(3'b111, 3'b111, 1'b1, 1'b1);
    issue3(3'b000, 3'b101, 1'b1, 1'b1);
    wait_idle3();

    // Backpressure: hold the result for five cycles.
    or3 = 1'b0;
    issue3(3'd5, 3'd6, 1'b0, 1'b1);
    n = 0;
    while (!ov3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ov3) fail_now("bp_out_valid_timeout3");
    repeat (5) begin
      @(negedge clk);
      check("bp_hold3", {55'd0, ov3, ir3, p3}, {55'd0, 1'b1, 1'b0, 6'd30});
    end
    or3 = 1'b1;
    @(negedge clk);
    check("bp_release3", {61'd0, ov3, ir3, busy3}, 64'b010);

    // Reset one edge into CALC discards the operation.
    issue3(3'd5, 3'd7, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midcalc_rst3", {55'd0, ir3, ov3, p3}, {55'd0, 1'b1, 1'b0, 6'd0});
    issue3(3'd2, 3'd3, 1'b0, 1'b1);
    wait_idle3();
    repeat (2) @(negedge clk);

    // Randomized WIDTH=8 traffic with in_valid toggling while busy.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      or8 = ($urandom_range(0, 3) != 0);
      if (k < 4) begin
        iv8 = 1'b1; a8 = ta[k]; b8 = tb[k]; s8 = ts[k];
      end else begin
        iv8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        s8 = 1'($urandom_range(0, 1));
      end
      if (ir8) check("ready_while_pending8", 64'(q8.size()), 64'd0);
      if (iv8 && ir8) begin
        q8.push_back('{ref_mul(32'(a8), 32'(b8), s8, 8), cyc + 1});
        naccept++;
        if (k < 4) k++;
      end
    end
    @(negedge clk);
    iv8 = 1'b0;
    or8 = 1'b1;
    n = 0;
    while ((q8.size() != 0 || !ir8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain8", 64'(q8.size()), 64'd0);
    if (naccept < 100) fail_now("too_few_accepts8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
